// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: latch update/flush, PC enable, halt state and perf counters.
// Latency: controls are combinational from the state and the inputs; halted and counters update on the next edge.
// Backpressure: a memory wait (ihit low, or a data request without dhit) freezes every latch and the PC.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             mem_halt,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             dec_jump,
    input  logic             ex_mem_to_reg,
    input  logic             ex_reg_wr,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             fd_update,
    output logic             fd_flush,
    output logic             de_update,
    output logic             de_flush,
    output logic             em_update,
    output logic             em_flush,
    output logic             mw_update,
    output logic             mw_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_HALTED = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic state;
    logic state_nxt;
    logic mem_req;
    logic advance;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    logic pc_en_c;
    logic fd_update_c;
    logic fd_flush_c;
    logic de_update_c;
    logic de_flush_c;
    logic em_update_c;
    logic mw_update_c;

    assign mem_req  = mem_dren | mem_dwen;
    assign advance  = (state == ST_RUN) & ihit & (~mem_req | dhit);
    assign load_use = ex_mem_to_reg & ex_reg_wr & (ex_rt != '0)
                    & ((ex_rt == dec_rs) | (ex_rt == dec_rt));

    always_comb begin
        state_nxt   = state;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_en_c     = 1'b0;
        fd_update_c = 1'b0;
        fd_flush_c  = 1'b0;
        de_update_c = 1'b0;
        de_flush_c  = 1'b0;
        em_update_c = 1'b0;
        mw_update_c = 1'b0;
        if (state == ST_HALTED) begin
            state_nxt = ST_HALTED;
        end else if (mem_halt && advance) begin
            // Drain the halt into writeback; younger stages stay frozen for good.
            em_update_c = 1'b1;
            mw_update_c = 1'b1;
            state_nxt   = ST_HALTED;
        end else if (!advance) begin
            stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
            pc_en_c     = 1'b1;
            fd_update_c = 1'b1;
            de_update_c = 1'b1;
            em_update_c = 1'b1;
            mw_update_c = 1'b1;
            fd_flush_c  = 1'b1;
            de_flush_c  = 1'b1;
            flush_inc   = 1'b1;
        end else if (load_use) begin
            // Hold fetch/decode, inject a bubble into execute, let the load move on.
            de_update_c = 1'b1;
            de_flush_c  = 1'b1;
            em_update_c = 1'b1;
            mw_update_c = 1'b1;
            stall_inc   = 1'b1;
        end else begin
            pc_en_c     = 1'b1;
            fd_update_c = 1'b1;
            de_update_c = 1'b1;
            em_update_c = 1'b1;
            mw_update_c = 1'b1;
            fd_flush_c  = dec_jump;
        end
    end

    assign pc_en     = pc_en_c     & ~RST;
    assign fd_update = fd_update_c & ~RST;
    assign fd_flush  = fd_flush_c  & ~RST;
    assign de_update = de_update_c & ~RST;
    assign de_flush  = de_flush_c  & ~RST;
    assign em_update = em_update_c & ~RST;
    assign mw_update = mw_update_c & ~RST;
    assign em_flush  = 1'b0;
    assign mw_flush  = 1'b0;
    assign halted    = (state == ST_HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall_inc && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_inc && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl built with 4-bit counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;
    localparam int RW = 5;

    // ctrl packing: {pc_en, fd_u, fd_f, de_u, de_f, em_u, em_f, mw_u, mw_f, halted}
    localparam logic [9:0] C_ADV    = 10'b1_10_10_10_10_0;
    localparam logic [9:0] C_FRZ    = 10'b0_00_00_00_00_0;
    localparam logic [9:0] C_BR     = 10'b1_11_11_10_10_0;
    localparam logic [9:0] C_LU     = 10'b0_00_11_10_10_0;
    localparam logic [9:0] C_JMP    = 10'b1_11_10_10_10_0;
    localparam logic [9:0] C_HADV   = 10'b0_00_00_10_10_0;
    localparam logic [9:0] C_HALTED = 10'b0_00_00_00_00_1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ihit, dhit, mem_dren, mem_dwen, mem_halt;
    logic [RW-1:0] dec_rs, dec_rt, ex_rt;
    logic          dec_jump, ex_mem_to_reg, ex_reg_wr, ex_branch_taken;
    logic          pc_en, fd_update, fd_flush, de_update, de_flush;
    logic          em_update, em_flush, mw_update, mw_flush, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    logic [9+2*CW:0] exp_q[$];

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.CNT_W(CW), .REG_W(RW)) dut (
        .CLK(CLK), .RST(RST),
        .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren), .mem_dwen(mem_dwen),
        .mem_halt(mem_halt), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_jump(dec_jump),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_wr(ex_reg_wr), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .fd_update(fd_update), .fd_flush(fd_flush),
        .de_update(de_update), .de_flush(de_flush),
        .em_update(em_update), .em_flush(em_flush),
        .mw_update(mw_update), .mw_flush(mw_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0; mem_halt = 1'b0;
        dec_rs = '0; dec_rt = '0; dec_jump = 1'b0;
        ex_mem_to_reg = 1'b0; ex_reg_wr = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0;
    endtask

    // Inputs are already applied (at negedge); push the expectation, observe, then move one cycle.
    task automatic cyc(input string tag, input logic [9:0] ctrl, input int st, input int fl);
        logic [9+2*CW:0] e;
        logic [9:0]      obs;
        exp_q.push_back({ctrl, st[CW-1:0], fl[CW-1:0]});
        #1;
        obs = {pc_en, fd_update, fd_flush, de_update, de_flush,
               em_update, em_flush, mw_update, mw_flush, halted};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".ctrl"},  32'(obs),       32'(e[9+2*CW:2*CW]));
            check({tag, ".stall"}, 32'(stall_cnt), 32'(e[2*CW-1:CW]));
            check({tag, ".flush"}, 32'(flush_cnt), 32'(e[CW-1:0]));
        end
        @(negedge CLK);
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        @(negedge CLK);
        cyc("reset", C_FRZ, 0, 0);
        RST = 1'b0;

        for (int i = 0; i < 5; i++) cyc("run", C_ADV, 0, 0);

        ex_mem_to_reg = 1'b1; ex_reg_wr = 1'b1; ex_rt = 5'd5; dec_rs = 5'd5;
        cyc("lu_rs", C_LU, 0, 0);
        ex_rt = 5'd0; dec_rs = 5'd0;
        cyc("lu_r0", C_ADV, 1, 0);
        ex_rt = 5'd7; dec_rt = 5'd7; dec_rs = 5'd3;
        cyc("lu_rt", C_LU, 1, 0);
        ex_reg_wr = 1'b0;
        cyc("lu_nowr", C_ADV, 2, 0);
        idle_inputs();

        mem_dren = 1'b1;
        for (int i = 0; i < 3; i++) cyc("dwait", C_FRZ, 2 + i, 0);
        dhit = 1'b1;
        cyc("dhit", C_ADV, 5, 0);
        mem_dren = 1'b0;
        cyc("dhit_noreq", C_ADV, 5, 0);
        dhit = 1'b0; ihit = 1'b0;
        cyc("iwait", C_FRZ, 5, 0);
        ihit = 1'b1; mem_dwen = 1'b1; dhit = 1'b1;
        cyc("dwrite", C_ADV, 6, 0);
        idle_inputs();

        ex_branch_taken = 1'b1; dec_jump = 1'b1;
        ex_mem_to_reg = 1'b1; ex_reg_wr = 1'b1; ex_rt = 5'd5; dec_rs = 5'd5;
        cyc("br_all", C_BR, 6, 0);
        idle_inputs();
        cyc("after_br", C_ADV, 6, 1);
        dec_jump = 1'b1;
        cyc("jump", C_JMP, 6, 1);
        idle_inputs();
        cyc("after_jmp", C_ADV, 6, 1);

        mem_halt = 1'b1; mem_dren = 1'b1;
        cyc("halt_wait", C_FRZ, 6, 1);
        dhit = 1'b1;
        cyc("halt_adv", C_HADV, 7, 1);
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            ihit = i[0]; dhit = ~i[0]; mem_dren = i[1]; ex_branch_taken = i[1];
            cyc("halted", C_HALTED, 7, 1);
        end

        idle_inputs();
        RST = 1'b1;
        cyc("rst_halt", C_FRZ, 0, 0);
        RST = 1'b0;
        cyc("rst_run", C_ADV, 0, 0);

        ihit = 1'b0;
        for (int i = 0; i < 20; i++) cyc("sat", C_FRZ, (i < 15) ? i : 15, 0);
        RST = 1'b1;
        cyc("rst_stall", C_FRZ, 0, 0);
        RST = 1'b0; ihit = 1'b1;
        cyc("post_rst", C_ADV, 0, 0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline latches: fetch/decode, decode/execute, execute/memory and memory/writeback. It drives every latch's update/flush pair and the PC enable. It resolves instruction- and data-memory wait stalls, load-use bubbles, taken-branch/jr squashes and decode-stage jump squashes. A sticky halt state and saturating performance counters are held in registers.

Parameters:
CNT_W, 16, width of the stall and flush performance counters (saturating)
REG_W, 5, register specifier width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
ihit  in  1  instruction memory returned fetch this cycle
dhit  in  1  data memory completed request this cycle
mem_dren  in  1  memory stage issuing data read
mem_dwen  in  1  memory stage issuing data write
mem_halt  in  1  halt instruction has reached the memory stage
dec_rs  in  REG_W  rs of instruction in decode
dec_rt  in  REG_W  rt of instruction in decode
dec_jump  in  1  j/jal decoded this cycle
ex_mem_to_reg  in  1  execute-stage instruction is a load
ex_reg_wr  in  1  execute-stage instruction writes a register
ex_rt  in  REG_W  destination rt of execute-stage load
ex_branch_taken  in  1  beq/bne taken or jr in execute
pc_en  out  1  PC register load enable
fd_update, fd_flush  out  1 each  fetch/decode latch control
de_update, de_flush  out  1 each  decode/execute latch control
em_update, em_flush  out  1 each  execute/memory latch control
mw_update, mw_flush  out  1 each  memory/writeback latch control
halted  out  1  pipeline halted (sticky)
stall_cnt  out  CNT_W  cycles in RUN with advance=0, plus load-use bubble cycles
flush_cnt  out  CNT_W  branch/jr squash events

Behaviour:
- States: RUN, HALTED. The state register is the only control flop. Counters and halted are registered.
- Reset (RST=1, async): state=RUN, halted=0, counters=0. All update, flush and pc_en outputs are forced to 0 while RST is high.
- Define mem_req = mem_dren | mem_dwen.
- Define advance = (state==RUN) & ihit & (~mem_req | dhit).
- Define load_use = ex_mem_to_reg & ex_reg_wr & (ex_rt!=0) & (ex_rt==dec_rs | ex_rt==dec_rt).
- Outputs are combinational from the state and inputs. Decisions are taken in this priority order:
  1. HALTED: all outputs 0, halted=1.
  2. RUN & mem_halt & advance: em_update=1 and mw_update=1. All other updates and pc_en are 0. All flushes are 0. Next state is HALTED, so halted=1 from the next cycle.
  3. RUN & ~advance: all updates, flushes and pc_en are 0 (full freeze). stall_cnt increments.
  4. ex_branch_taken: pc_en=1, all updates=1, fd_flush=1, de_flush=1. flush_cnt increments. A simultaneous load_use or dec_jump is ignored.
  5. load_use: pc_en=0, fd_update=0, de_flush=1 (bubble), em_update=1, mw_update=1. stall_cnt increments. The bubble persists until the load leaves execute; there is no extra state.
  6. dec_jump: pc_en=1, all updates=1, fd_flush=1.
  7. Otherwise: pc_en=1, all updates=1, all flushes=0.
- A flush is asserted only together with its latch's update. em_flush and mw_flush are always 0 (reserved).
- Counters saturate at 2^CNT_W-1 and do not wrap.
- A dhit while mem_req=0 is ignored. An ihit while state=HALTED is ignored.
- RST asserted mid-stall or mid-halt returns the block to RUN immediately. Counters clear.

Test Plan:
- Reset, then ihit=1, dhit=0, no requests for 5 cycles: pc_en and all updates are 1 each cycle, flushes 0, stall_cnt=0.
- Load lw r5 in execute (ex_mem_to_reg=1, ex_reg_wr=1, ex_rt=5) with dec_rs=5, ihit=1: pc_en=0, fd_update=0, de_flush=1, em_update=1, stall_cnt goes 0->1. Repeat with ex_rt=0: no stall.
- mem_dren=1, dhit=0 for 3 cycles, then dhit=1: three frozen cycles with all outputs 0 and stall_cnt=3, then full advance.
- ex_branch_taken=1 together with load_use=1 and dec_jump=1: fd_flush=1, de_flush=1, pc_en=1, flush_cnt=1, no bubble.
- mem_halt=1 with ihit=1: one cycle with only em_update and mw_update high. Next cycle halted=1 and all controls are 0 despite ihit/dhit toggling. Pulsing RST returns to RUN with halted=0.
- Force stall_cnt near saturation (CNT_W=4 build, 20 stalled cycles): stall_cnt holds at 15.
